// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl
//   Synchronous FIFO controller wrapped around an external dual-port RAM.
//   Port A of the RAM is the write side and Port B is the read side.
//   The Port A read strobe and all Port B write signals are tied off.
//   The RAM registers its Port B output, so a read is valid one cycle after
//   it is accepted.
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   wr_en, wr_data           producer write request and data
//   rd_en                    consumer read request
//   rd_data, rd_valid        read data and its valid strobe
//   full, almost_full,
//   empty, count             registered occupancy status
//   overflow, underflow      sticky error flags, cleared only by rst
//   ram_*                    RAM control signals out, ram_out_b data in
module dpram_fifo_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 3,
    parameter int AFULL_LEVEL = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              almost_full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic [DATA_W-1:0] ram_a,
    output logic [ADDR_W-1:0] ram_addrs_a,
    output logic              ram_wra,
    output logic              ram_rda,
    output logic [ADDR_W-1:0] ram_addrs_b,
    output logic              ram_rdb,
    output logic              ram_wrb,
    output logic [DATA_W-1:0] ram_b,
    input  logic [DATA_W-1:0] ram_out_b
);

    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AFULL_C = AFULL_LEVEL[ADDR_W:0];

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   count_next;
    logic              wr_acc;
    logic              rd_acc;

    // Gating on the registered flags also guarantees that Port A and Port B
    // never address the same entry in the same cycle.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    assign ram_wra     = wr_acc;
    assign ram_addrs_a = wptr;
    assign ram_a       = wr_data;
    assign ram_rdb     = rd_acc;
    assign ram_addrs_b = rptr;
    assign ram_rda     = 1'b0;
    assign ram_wrb     = 1'b0;
    assign ram_b       = '0;

    assign rd_data = ram_out_b;

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            rd_valid    <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            // Pointers wrap naturally at DEPTH through ADDR_W-bit overflow.
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
            end
            count       <= count_next;
            empty       <= (count_next == '0);
            full        <= (count_next == DEPTH_C);
            almost_full <= (count_next >= AFULL_C);
            rd_valid    <= rd_acc;
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
